// File: rtl/fpu_pkg.sv
// Shared encodings for the FP pipeline control: op classes, forwarding
// selects and the iterative-op FSM states.
package fpu_pkg;

   // Op class (result-mux select); fc[2:1] of the ID op maps onto these.
   localparam logic [1:0] OPC_ADD  = 2'd0;
   localparam logic [1:0] OPC_MUL  = 2'd1;
   localparam logic [1:0] OPC_DIV  = 2'd2;
   localparam logic [1:0] OPC_SQRT = 2'd3;

   // Operand forwarding select for fs / ft.
   localparam logic [1:0] FWD_NONE = 2'b00;   // regfile value
   localparam logic [1:0] FWD_EX   = 2'b01;   // result leaving the last execute stage
   localparam logic [1:0] FWD_WB   = 2'b10;   // result sitting in writeback

   typedef enum logic [1:0] {
      IT_IDLE = 2'd0,
      IT_BUSY = 2'd1,
      IT_DONE = 2'd2
   } iter_state_e;

   // Youngest producer wins: last execute stage beats writeback.
   function automatic logic [1:0] fwd_sel(input logic use_src,
                                          input logic hit_ex,
                                          input logic hit_wb);
      if (!use_src)
         return FWD_NONE;
      else if (hit_ex)
         return FWD_EX;
      else if (hit_wb)
         return FWD_WB;
      else
         return FWD_NONE;
   endfunction

endpackage

// File: rtl/fpu_iter_ctrl.sv
// Iterative-op (fdiv/fsqrt) stall sequencer. Holds ID for ITER_LAT cycles,
// then lets the op issue once without re-arming on the same instruction.
module fpu_iter_ctrl
   import fpu_pkg::*;
#(
   parameter int ITER_LAT = 10
)(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             ein,
   input  logic                             iter_op,
   input  logic                             stall_hz,
   output logic                             st_iter,
   output logic [$clog2(ITER_LAT+1)-1:0]    iter_cnt
);

   localparam int CNT_W = $clog2(ITER_LAT+1);

   iter_state_e state;
   logic        start;

   // A hazard stall takes priority; the iterative sequence only starts
   // once the operands are clear.
   assign start = ein & iter_op & ~stall_hz;

   // Stall request: the arming cycle counts as the first stall cycle.
   always_comb begin
      st_iter = 1'b0;
      unique case (state)
         IT_IDLE: st_iter = start;
         IT_BUSY: st_iter = 1'b1;
         default: st_iter = 1'b0;
      endcase
   end

   // State and remaining-cycle counter. BUSY covers the ITER_LAT-1 cycles
   // after arming; leaving when the count would reach zero makes the total
   // stall exactly ITER_LAT cycles. In DONE st_iter is low, so adv == ein.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IT_IDLE;
         iter_cnt <= '0;
      end else begin
         unique case (state)
            IT_IDLE: if (start) begin
               iter_cnt <= CNT_W'(ITER_LAT-1);
               state    <= (ITER_LAT == 1) ? IT_DONE : IT_BUSY;
            end
            IT_BUSY: begin
               iter_cnt <= iter_cnt - CNT_W'(1);
               if (iter_cnt <= CNT_W'(1))
                  state <= IT_DONE;
            end
            IT_DONE: if (ein)
               state <= IT_IDLE;
            default: state <= IT_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/fpu_pipe_ctrl.sv
// FP pipeline control: stages dest reg / write enable / op class through
// E1..E(STAGES) and W, detects RAW hazards for ID and picks forwarding.
module fpu_pipe_ctrl
   import fpu_pkg::*;
#(
   parameter int STAGES   = 3,
   parameter int RN_W     = 5,
   parameter int OPC_W    = 2,
   parameter int ITER_LAT = 10
)(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             ein,
   input  logic                             cancel_e1,
   input  logic [2:0]                       fc,
   input  logic                             wf,
   input  logic [RN_W-1:0]                  fd,
   input  logic [RN_W-1:0]                  fs,
   input  logic [RN_W-1:0]                  ft,
   input  logic                             use_fs,
   input  logic                             use_ft,
   output logic                             adv,
   output logic                             issue,
   output logic                             st_iter,
   output logic                             stall_hz,
   output logic [$clog2(ITER_LAT+1)-1:0]    iter_cnt,
   output logic                             sub_e1,
   output logic [STAGES*RN_W-1:0]           stage_n,
   output logic [STAGES*OPC_W-1:0]          stage_c,
   output logic [STAGES-1:0]                stage_w,
   output logic [RN_W-1:0]                  wn,
   output logic                             ww,
   output logic [1:0]                       fwd_s,
   output logic [1:0]                       fwd_t
);

   // Index 0..STAGES-1 are E1..E(STAGES); index STAGES is writeback.
   logic [STAGES:0]              wen_pipe;
   logic [STAGES:0][RN_W-1:0]    rn_pipe;
   logic [STAGES-1:0][OPC_W-1:0] opc_pipe;
   logic [STAGES-1:0]            w_eff;
   logic [STAGES-1:0]            hit_s, hit_t;
   logic [OPC_W-1:0]             opc_id;

   assign opc_id = OPC_W'(fc[2:1]);

   assign adv   = ein & ~st_iter;
   assign issue = adv & ~stall_hz;

   // E1 keeps its ungated enable while stalled; the cancel only masks what
   // is seen and what shifts onward.
   always_comb begin
      w_eff    = wen_pipe[STAGES-1:0];
      w_eff[0] = wen_pipe[0] & ~cancel_e1;
   end

   assign stage_w = w_eff;
   assign stage_n = rn_pipe[STAGES-1:0];
   assign stage_c = opc_pipe;
   assign ww      = wen_pipe[STAGES];
   assign wn      = rn_pipe[STAGES];

   // Per-stage source match.
   for (genvar k = 0; k < STAGES; k++) begin : g_match
      assign hit_s[k] = w_eff[k] & (rn_pipe[k] == fs);
      assign hit_t[k] = w_eff[k] & (rn_pipe[k] == ft);
   end

   // Producers before the last execute stage have no result yet: stall.
   assign stall_hz = (use_fs & (|hit_s[STAGES-2:0])) |
                     (use_ft & (|hit_t[STAGES-2:0]));

   assign fwd_s = fwd_sel(use_fs, hit_s[STAGES-1], ww & (wn == fs));
   assign fwd_t = fwd_sel(use_ft, hit_t[STAGES-1], ww & (wn == ft));

   // Stage registers: shift on advance, E1 gets the ID op or a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         wen_pipe <= '0;
         rn_pipe  <= '0;
         opc_pipe <= '0;
         sub_e1   <= 1'b0;
      end else if (adv) begin
         wen_pipe[0] <= wf & issue;
         rn_pipe[0]  <= issue ? fd : '0;
         opc_pipe[0] <= issue ? opc_id : '0;
         sub_e1      <= issue & fc[0];
         for (int k = 1; k < STAGES; k++) begin
            wen_pipe[k] <= w_eff[k-1];
            rn_pipe[k]  <= rn_pipe[k-1];
            opc_pipe[k] <= opc_pipe[k-1];
         end
         wen_pipe[STAGES] <= w_eff[STAGES-1];
         rn_pipe[STAGES]  <= rn_pipe[STAGES-1];
      end
   end

   fpu_iter_ctrl #(.ITER_LAT(ITER_LAT)) u_iter (
      .clk      (clk),
      .rst      (rst),
      .ein      (ein),
      .iter_op  (fc[2]),
      .stall_hz (stall_hz),
      .st_iter  (st_iter),
      .iter_cnt (iter_cnt)
   );

endmodule

// File: tb/tb_fpu_pipe_ctrl.sv
// Directed bench for fpu_pipe_ctrl (STAGES=3, ITER_LAT=4). Writebacks are
// checked by a scoreboard monitor; per-cycle control outputs inline.
module tb_fpu_pipe_ctrl;

   localparam int STAGES   = 3;
   localparam int RN_W     = 5;
   localparam int OPC_W    = 2;
   localparam int ITER_LAT = 4;

   logic clk = 1'b0;
   logic rst, ein, cancel_e1, wf, use_fs, use_ft;
   logic [2:0] fc;
   logic [RN_W-1:0] fd, fs, ft;
   logic adv, issue, st_iter, stall_hz, sub_e1, ww;
   logic [$clog2(ITER_LAT+1)-1:0] iter_cnt;
   logic [STAGES*RN_W-1:0]  stage_n;
   logic [STAGES*OPC_W-1:0] stage_c;
   logic [STAGES-1:0]       stage_w;
   logic [RN_W-1:0]         wn;
   logic [1:0]              fwd_s, fwd_t;

   int vectors = 0;
   int miscompares = 0;
   logic [RN_W-1:0] exp_q[$];
   logic wb_new = 1'b0;

   always #5 clk = ~clk;

   fpu_pipe_ctrl #(.STAGES(STAGES), .RN_W(RN_W), .OPC_W(OPC_W), .ITER_LAT(ITER_LAT)) dut (
      .clk(clk), .rst(rst), .ein(ein), .cancel_e1(cancel_e1), .fc(fc), .wf(wf),
      .fd(fd), .fs(fs), .ft(ft), .use_fs(use_fs), .use_ft(use_ft),
      .adv(adv), .issue(issue), .st_iter(st_iter), .stall_hz(stall_hz),
      .iter_cnt(iter_cnt), .sub_e1(sub_e1), .stage_n(stage_n), .stage_c(stage_c),
      .stage_w(stage_w), .wn(wn), .ww(ww), .fwd_s(fwd_s), .fwd_t(fwd_t)
   );

   // A writeback is new when the pipe advanced on the edge that loaded W.
   always @(posedge clk) wb_new <= adv & ~rst;

   // Scoreboard monitor: every new writeback must match the oldest expected.
   always @(negedge clk) begin
      if (ww && wb_new) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL wb_unexpected: got ww=1 wn=%0d, required no writeback", wn);
         end else begin
            logic [RN_W-1:0] e;
            e = exp_q.pop_front();
            if (wn !== e) begin
               miscompares++;
               $display("FAIL wb_reg: got wn=%0d, required %0d", wn, e);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d", nm, got, exp);
      end
   endtask

   task automatic drive(input logic e, input logic [2:0] f, input logic w,
                        input logic [RN_W-1:0] d, input logic [RN_W-1:0] s,
                        input logic [RN_W-1:0] t, input logic us, input logic ut);
      ein = e; fc = f; wf = w; fd = d; fs = s; ft = t; use_fs = us; use_ft = ut;
   endtask

   task automatic nop();
      drive(1'b1, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; cancel_e1 = 1'b0;
      drive(1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      tick(); tick();
      rst = 1'b0; settle();
      chk("rst_stage_w", stage_w, 0);
      chk("rst_ww", ww, 0);
      chk("rst_wn", wn, 0);
      chk("rst_sub_e1", sub_e1, 0);
      chk("rst_iter_cnt", iter_cnt, 0);
      chk("rst_st_iter", st_iter, 0);
      chk("rst_stall_hz", stall_hz, 0);

      // ---- producer fd=7, dependent fs=7 one cycle behind ----
      drive(1'b1, 3'b000, 1'b1, 5'd7, 5'd1, 5'd2, 1'b0, 1'b0); settle();
      chk("a0_issue", issue, 1); chk("a0_adv", adv, 1);
      exp_q.push_back(5'd7); tick();
      drive(1'b1, 3'b010, 1'b1, 5'd8, 5'd7, 5'd0, 1'b1, 1'b0); settle();
      chk("a1_stage_w", stage_w, 3'b001); chk("a1_stage_n", stage_n, 7);
      chk("a1_stall", stall_hz, 1); chk("a1_issue", issue, 0); chk("a1_fwd_s", fwd_s, 0);
      tick(); settle();
      chk("a2_stage_w", stage_w, 3'b010); chk("a2_stage_n", stage_n, 7 << 5);
      chk("a2_stall", stall_hz, 1);
      tick(); settle();
      chk("a3_stage_w", stage_w, 3'b100); chk("a3_stall", stall_hz, 0);
      chk("a3_fwd_s", fwd_s, 2'b01); chk("a3_issue", issue, 1);
      exp_q.push_back(5'd8); tick();
      ein = 1'b0; settle();
      chk("a4_ww", ww, 1); chk("a4_wn", wn, 7); chk("a4_stage_w", stage_w, 3'b001);
      chk("a4_fwd_s", fwd_s, 2'b10); chk("a4_adv", adv, 0);
      tick();
      // ft source against producer fd=8
      drive(1'b1, 3'b000, 1'b0, 5'd0, 5'd0, 5'd8, 1'b0, 1'b1); settle();
      chk("a5_stall_t", stall_hz, 1); chk("a5_issue", issue, 0); chk("a5_fwd_t", fwd_t, 0);
      tick(); settle();
      chk("a6_stall_t", stall_hz, 1); chk("a6_stage_w", stage_w, 3'b010);
      tick(); settle();
      chk("a7_stall_t", stall_hz, 0); chk("a7_fwd_t", fwd_t, 2'b01); chk("a7_issue", issue, 1);
      tick(); settle();
      chk("a8_fwd_t", fwd_t, 2'b10); chk("a8_ww", ww, 1); chk("a8_wn", wn, 8);
      nop(); repeat (4) tick();

      // ---- iterative fdiv, ein held high ----
      drive(1'b1, 3'b100, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0); settle();
      chk("b0_st_iter", st_iter, 1); chk("b0_adv", adv, 0);
      chk("b0_issue", issue, 0); chk("b0_iter_cnt", iter_cnt, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("b_busy_st_iter", st_iter, 1); chk("b_busy_cnt", iter_cnt, 3 - i);
         tick();
      end
      settle();
      chk("b4_st_iter", st_iter, 0); chk("b4_iter_cnt", iter_cnt, 0); chk("b4_issue", issue, 1);
      exp_q.push_back(5'd3); tick();
      // back-to-back fsqrt (sub bit set); ein drops during the stall
      drive(1'b1, 3'b111, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0); settle();
      chk("b5_stage_c", stage_c[1:0], 2); chk("b5_stage_w", stage_w, 3'b001);
      chk("b5_sub_e1", sub_e1, 0); chk("b5_st_iter", st_iter, 1);
      tick();
      ein = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("b_busy2_st_iter", st_iter, 1); chk("b_busy2_cnt", iter_cnt, 3 - i);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("b_done_st_iter", st_iter, 0); chk("b_done_adv", adv, 0);
         chk("b_done_cnt", iter_cnt, 0);
         tick();
      end
      ein = 1'b1; settle();
      chk("b12_st_iter", st_iter, 0); chk("b12_issue", issue, 1);
      exp_q.push_back(5'd5); tick();
      nop(); settle();
      chk("b13_stage_c", stage_c[1:0], 3); chk("b13_sub_e1", sub_e1, 1);
      chk("b13_stage_w", stage_w, 3'b011); chk("b13_stage_n", stage_n, (3 << 5) | 5);
      chk("b13_st_iter", st_iter, 0);
      repeat (5) tick();

      // ---- cancel of E1 op fd=4 ----
      drive(1'b1, 3'b000, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0); settle();
      chk("c0_issue", issue, 1); tick();
      drive(1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      cancel_e1 = 1'b1; settle();
      chk("c1_stage_w", stage_w, 0); chk("c1_stage_n", stage_n, 4);
      cancel_e1 = 1'b0; settle();
      chk("c1_held_w", stage_w, 3'b001);
      cancel_e1 = 1'b1; tick();
      nop(); settle();
      chk("c2_stage_w", stage_w, 0); chk("c2_adv", adv, 1);
      tick();
      cancel_e1 = 1'b0; settle();
      chk("c3_stage_w", stage_w, 0); chk("c3_stage_n", stage_n, 4 << 5);
      tick(); settle();
      chk("c4_stage_w", stage_w, 0); chk("c4_stage_n", stage_n, 4 << 10);
      tick(); settle();
      chk("c5_ww", ww, 0); chk("c5_wn", wn, 4);
      tick();

      // ---- reset while BUSY ----
      drive(1'b1, 3'b000, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0); settle(); tick();
      drive(1'b1, 3'b100, 1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0); settle();
      chk("d1_st_iter", st_iter, 1); tick(); settle();
      chk("d2_iter_cnt", iter_cnt, 3); tick(); settle();
      chk("d3_iter_cnt", iter_cnt, 2); chk("d3_st_iter", st_iter, 1);
      rst = 1'b1; tick();
      rst = 1'b0;
      drive(1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); settle();
      chk("d4_st_iter", st_iter, 0); chk("d4_iter_cnt", iter_cnt, 0);
      chk("d4_stage_w", stage_w, 0); chk("d4_ww", ww, 0); chk("d4_stage_n", stage_n, 0);
      nop(); settle();
      chk("d4_issue", issue, 1);
      repeat (5) tick();

      chk("wb_queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
